// File: rtl/mesi_pkg.sv
// Shared types and defaults for the two-core MESI bus controller.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mesi_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    BUS_RD    = 2'd0,
    BUS_RDX   = 2'd1,
    BUS_UPGR  = 2'd2,
    BUS_FLUSH = 2'd3
  } bus_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_MEM,
    ST_WB,
    ST_RESP
  } bus_state_e;

  function automatic logic peer_of(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/mesi_rr_arb.sv
// Two-requester round-robin arbiter with a last-grant pointer.
// Latency: grant is combinational; the pointer updates on the clock edge when en is high.
// Backpressure: requesters hold req until they are served; en gates pointer updates.
module mesi_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  logic last;

  assign gnt_vld = |req;
  // On a tie, the core that was not granted last wins.
  assign gnt_idx = (&req) ? ~last : req[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (en && gnt_vld) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// Shared-bus responder: arbitrates core requests, snoops the peer, and serves data from the peer or backing memory.
// Latency: 2 cycles for Flush, BusUpgr and dirty intervention; MEM_LAT+2 cycles for a clean read.
// Backpressure: one transaction at a time; a core holds req_valid until its resp_valid pulse.
module mesi_bus_ctrl
  import mesi_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0][1:0]        req_cmd,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic                   snoop_valid,
  output logic [1:0]             snoop_cmd,
  output logic [ADDR_W-1:0]      snoop_addr,
  output logic                   snoop_src,
  input  logic [1:0]             snoop_hit,
  input  logic [1:0]             snoop_dirty,
  input  logic [1:0][DATA_W-1:0] snoop_data,
  output logic [1:0]             resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_excl,
  output logic                   proto_err
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  bus_state_e        state;
  bus_cmd_e          cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              src_q;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              gnt_vld;
  logic              gnt_idx;
  logic              peer;
  logic              peer_hit;
  logic              peer_dirty;
  logic              own_hit;
  logic              both_dirty;
  logic [DATA_W-1:0] intv_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  mesi_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (state == ST_IDLE),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign peer       = peer_of(src_q);
  assign peer_hit   = snoop_hit[peer] | snoop_dirty[peer];
  assign peer_dirty = snoop_dirty[peer];
  assign own_hit    = snoop_hit[src_q] | snoop_dirty[src_q];
  assign both_dirty = &snoop_dirty;
  // Two Modified copies is already an error; core 0's copy is taken as the winner.
  assign intv_data  = both_dirty ? snoop_data[0] : snoop_data[peer];

  assign mem_we    = rst && ((state == ST_WB) || ((state == ST_SNOOP) && peer_dirty));
  assign mem_wdata = (state == ST_WB) ? wdata_q : intv_data;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cmd_q       <= BUS_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      src_q       <= 1'b0;
      cnt         <= '0;
      snoop_valid <= 1'b0;
      snoop_cmd   <= '0;
      snoop_addr  <= '0;
      snoop_src   <= 1'b0;
      resp_valid  <= '0;
      resp_data   <= '0;
      resp_excl   <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      snoop_valid <= 1'b0;
      resp_valid  <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            src_q   <= gnt_idx;
            cmd_q   <= bus_cmd_e'(req_cmd[gnt_idx]);
            addr_q  <= req_addr[gnt_idx];
            wdata_q <= req_wdata[gnt_idx];
            if (bus_cmd_e'(req_cmd[gnt_idx]) == BUS_FLUSH) begin
              state <= ST_WB;
            end else begin
              state       <= ST_SNOOP;
              snoop_valid <= 1'b1;
              snoop_cmd   <= req_cmd[gnt_idx];
              snoop_addr  <= req_addr[gnt_idx];
              snoop_src   <= gnt_idx;
            end
          end
        end
        ST_SNOOP: begin
          if (own_hit || both_dirty) begin
            proto_err <= 1'b1;
          end
          resp_excl <= (cmd_q == BUS_RD) ? ~peer_hit : 1'b1;
          cnt       <= '0;
          if (peer_dirty) begin
            resp_data         <= intv_data;
            resp_valid[src_q] <= 1'b1;
            state             <= ST_RESP;
          end else if (cmd_q == BUS_UPGR) begin
            resp_valid[src_q] <= 1'b1;
            state             <= ST_RESP;
          end else begin
            state <= ST_MEM;
          end
        end
        ST_MEM: begin
          if (cnt == CNT_W'(MEM_LAT - 1)) begin
            resp_data         <= mem[addr_q];
            resp_valid[src_q] <= 1'b1;
            state             <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WB: begin
          resp_excl         <= 1'b0;
          resp_valid[src_q] <= 1'b1;
          state             <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Self-checking bench for mesi_bus_ctrl: directed vector table, arbitration ties, reset aborts
// and randomized transactions scored against a rule-level reference model.
module tb_mesi_bus_ctrl;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             req_valid;
  logic [1:0][1:0]        req_cmd;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic                   snoop_valid;
  logic [1:0]             snoop_cmd;
  logic [ADDR_W-1:0]      snoop_addr;
  logic                   snoop_src;
  logic [1:0]             snoop_hit;
  logic [1:0]             snoop_dirty;
  logic [1:0][DATA_W-1:0] snoop_data;
  logic [1:0]             resp_valid;
  logic [DATA_W-1:0]      resp_data;
  logic                   resp_excl;
  logic                   proto_err;

  mesi_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_excl(resp_excl), .proto_err(proto_err)
  );

  typedef struct {
    int         core;
    logic [1:0] cmd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] hit;
    logic [1:0] dirty;
    logic [7:0] sd0;
    logic [7:0] sd1;
    int         cyc;
    logic       chk_data;
    logic [7:0] data;
    logic       excl;
    logic       snooped;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int         obs_cyc [2];
  logic [7:0] obs_data [2];
  logic       obs_excl [2];
  int         first_core;
  int         snoop_cnt;
  int         spurious;
  logic [1:0] snp_cmd;
  logic [7:0] snp_addr;
  logic       snp_src;

  logic [7:0] model_mem [256];
  bit         model_known [256];
  logic       exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    req_valid   = '0;
    snoop_hit   = '0;
    snoop_dirty = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge of the following IDLE cycle.
  task automatic wait_resps(input logic [1:0] mask, input int budget);
    logic [1:0] pend;
    pend       = mask;
    obs_cyc[0] = -1;
    obs_cyc[1] = -1;
    first_core = -1;
    snoop_cnt  = 0;
    spurious   = 0;
    req_valid  = mask;
    for (int cyc = 1; cyc <= budget && pend != 2'b00; cyc++) begin
      @(negedge clk);
      if (snoop_valid) begin
        snoop_cnt++;
        snp_cmd  = snoop_cmd;
        snp_addr = snoop_addr;
        snp_src  = snoop_src;
      end
      for (int c = 0; c < 2; c++) begin
        if (resp_valid[c]) begin
          if (!pend[c]) begin
            spurious++;
          end else begin
            pend[c]      = 1'b0;
            req_valid[c] = 1'b0;
            obs_cyc[c]   = cyc;
            obs_data[c]  = resp_data;
            obs_excl[c]  = resp_excl;
            if (first_core < 0) first_core = c;
          end
        end
      end
    end
    check("resp_timeout_pending", {30'd0, pend}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    if (resp_valid != 2'b00 || snoop_valid) spurious++;
  endtask

  task automatic run_single(input vec_t v, input string tag);
    int c;
    c              = v.core;
    req_cmd[c]     = v.cmd;
    req_addr[c]    = v.addr;
    req_wdata[c]   = v.wdata;
    snoop_hit      = v.hit;
    snoop_dirty    = v.dirty;
    snoop_data[0]  = v.sd0;
    snoop_data[1]  = v.sd1;
    wait_resps(c ? 2'b10 : 2'b01, 30);
    snoop_hit   = '0;
    snoop_dirty = '0;
    check({tag, "_cycle"}, obs_cyc[c], v.cyc);
    if (v.chk_data) check({tag, "_data"}, {24'd0, obs_data[c]}, {24'd0, v.data});
    check({tag, "_excl"}, {31'd0, obs_excl[c]}, {31'd0, v.excl});
    check({tag, "_snoop_count"}, snoop_cnt, v.snooped ? 1 : 0);
    if (v.snooped) begin
      check({tag, "_snoop_fields"}, {21'd0, snp_cmd, snp_addr, snp_src},
            {21'd0, v.cmd, v.addr, c[0]});
    end
    check({tag, "_extra_pulses"}, spurious, 0);
  endtask

  // Rule-level reference: outcome of one transaction from the command, peer response and memory image.
  function automatic vec_t model(input vec_t v);
    int         peer;
    logic [7:0] peer_data;
    peer       = 1 - v.core;
    peer_data  = peer ? v.sd1 : v.sd0;
    v.snooped  = (v.cmd != 2'd3);
    v.chk_data = 1'b0;
    v.data     = 8'h00;
    if (v.cmd == 2'd3) begin
      v.cyc  = 2;
      v.excl = 1'b0;
      model_mem[v.addr]   = v.wdata;
      model_known[v.addr] = 1'b1;
    end else begin
      if (v.hit[v.core] || v.dirty[v.core] || (v.dirty == 2'b11)) exp_err = 1'b1;
      if (v.dirty[peer]) begin
        v.cyc      = 2;
        v.data     = (v.dirty == 2'b11) ? v.sd0 : peer_data;
        v.chk_data = 1'b1;
        v.excl     = (v.cmd != 2'd0);
        model_mem[v.addr]   = v.data;
        model_known[v.addr] = 1'b1;
      end else if (v.cmd == 2'd2) begin
        v.cyc  = 2;
        v.excl = 1'b1;
      end else begin
        v.cyc      = MEM_LAT + 2;
        v.chk_data = model_known[v.addr];
        v.data     = model_mem[v.addr];
        v.excl     = (v.cmd == 2'd0) ? !v.hit[peer] : 1'b1;
      end
    end
    return v;
  endfunction

  task automatic tie_test(input int exp_first, input string tag);
    req_cmd[0]  = 2'd0;
    req_cmd[1]  = 2'd0;
    req_addr[0] = 8'h01;
    req_addr[1] = 8'h02;
    snoop_hit   = '0;
    snoop_dirty = '0;
    wait_resps(2'b11, 40);
    check({tag, "_first_grant"}, first_core, exp_first);
    check({tag, "_first_cycle"}, obs_cyc[exp_first], MEM_LAT + 2);
    check({tag, "_second_cycle"}, obs_cyc[1 - exp_first], 2 * (MEM_LAT + 2) + 1);
    check({tag, "_snoops"}, snoop_cnt, 2);
  endtask

  vec_t vecs [6];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1);
  end

  initial begin
    req_valid   = '0;
    req_cmd     = '0;
    req_addr    = '0;
    req_wdata   = '0;
    snoop_hit   = '0;
    snoop_dirty = '0;
    snoop_data  = '0;
    exp_err     = 1'b0;
    for (int i = 0; i < 256; i++) model_known[i] = 1'b0;

    //          core cmd   addr   wdata  hit    dirty  sd0    sd1    cyc chk  data   excl  snooped
    vecs[0] = '{0, 2'd3, 8'hAA, 8'h5C, 2'b00, 2'b00, 8'h00, 8'h00, 2,  1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1, 2'd0, 8'hAA, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4,  1'b1, 8'h5C, 1'b1, 1'b1};
    vecs[2] = '{1, 2'd0, 8'h10, 8'h00, 2'b01, 2'b00, 8'h00, 8'h00, 4,  1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{1, 2'd1, 8'h20, 8'h00, 2'b01, 2'b01, 8'h3F, 8'h00, 2,  1'b1, 8'h3F, 1'b1, 1'b1};
    vecs[4] = '{1, 2'd0, 8'h20, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4,  1'b1, 8'h3F, 1'b1, 1'b1};
    vecs[5] = '{0, 2'd2, 8'h30, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2,  1'b0, 8'h00, 1'b1, 1'b1};

    do_reset();
    check("reset_outputs",
          {8'd0, snoop_valid, snoop_cmd, snoop_addr, snoop_src, resp_valid, resp_data, resp_excl, proto_err},
          32'd0);

    // First tie after reset goes to core 0; a lone core-0 grant then makes core 1 win the next tie.
    tie_test(0, "tie_after_reset");
    v = '{0, 2'd0, 8'h03, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4, 1'b0, 8'h00, 1'b1, 1'b1};
    run_single(v, "lone_core0");
    tie_test(1, "tie_after_core0");

    foreach (vecs[i]) run_single(vecs[i], $sformatf("vec%0d", i));
    check("no_err_after_table", {31'd0, proto_err}, 32'd0);

    for (int a = 0; a < 8; a++) begin
      v = '{a % 2, 2'd3, 8'h40 + a[7:0], 8'($urandom), 2'b00, 2'b00, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0};
      v = model(v);
      run_single(v, $sformatf("fill%0d", a));
    end
    for (int n = 0; n < 60; n++) begin
      int peer;
      v.core  = int'($urandom_range(0, 1));
      v.cmd   = 2'($urandom_range(0, 3));
      v.addr  = 8'h40 + 8'($urandom_range(0, 7));
      v.wdata = 8'($urandom);
      v.sd0   = 8'($urandom);
      v.sd1   = 8'($urandom);
      v.hit   = 2'b00;
      v.dirty = 2'b00;
      peer    = 1 - v.core;
      if (v.cmd != 2'd3) begin
        v.hit[peer] = 1'($urandom_range(0, 1));
        if (v.hit[peer]) v.dirty[peer] = 1'($urandom_range(0, 1));
      end
      v = model(v);
      run_single(v, $sformatf("rnd%0d", n));
    end
    check("err_after_random", {31'd0, proto_err}, {31'd0, exp_err});

    // Both peers dirty: error flagged, core 0's data wins and lands in memory.
    v = '{0, 2'd0, 8'h50, 8'h00, 2'b11, 2'b11, 8'h11, 8'h22, 2, 1'b1, 8'h11, 1'b0, 1'b1};
    run_single(v, "both_dirty");
    check("err_both_dirty", {31'd0, proto_err}, 32'd1);
    v = '{1, 2'd0, 8'h50, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4, 1'b1, 8'h11, 1'b1, 1'b1};
    run_single(v, "read_after_both_dirty");
    check("err_sticky", {31'd0, proto_err}, 32'd1);

    // Reset during MEM: outputs clear at once and the aborted read never responds.
    req_cmd[0]  = 2'd0;
    req_addr[0] = 8'hAA;
    req_valid   = 2'b01;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    req_valid = '0;
    #1;
    check("reset_in_mem_outputs",
          {8'd0, snoop_valid, snoop_cmd, snoop_addr, snoop_src, resp_valid, resp_data, resp_excl, proto_err},
          32'd0);
    spurious = 0;
    repeat (3) @(negedge clk) if (resp_valid != 2'b00) spurious++;
    rst = 1'b1;
    repeat (MEM_LAT + 4) @(negedge clk) if (resp_valid != 2'b00) spurious++;
    check("reset_in_mem_no_resp", spurious, 0);

    // Reset during WB: the Flush write is dropped, memory keeps its old line.
    req_cmd[0]   = 2'd3;
    req_addr[0]  = 8'hAA;
    req_wdata[0] = 8'hEE;
    req_valid    = 2'b01;
    @(negedge clk);
    #2 rst = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    v = '{1, 2'd0, 8'hAA, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 4, 1'b1, 8'h5C, 1'b1, 1'b1};
    run_single(v, "read_after_wb_abort");
    check("err_cleared_by_reset", {31'd0, proto_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
